// File: rtl/traffic_light_timed.sv
// traffic_light_timed
//   Timed road/pedestrian crossing controller. Six phases:
//   GREEN, YELLOW, ALLRED1, WALK, PEDCLR and ALLRED2. Each phase has a
//   duration counter that only advances on tick strobes. Road green has a
//   guaranteed minimum, and a pedestrian request is latched so that a short
//   button press is never lost.
// Ports
//   clock       rising-edge system clock
//   clear       asynchronous active-high reset
//   tick        time-base strobe; phase timers advance only when it is high
//   waiting     pedestrian request (level or single-cycle pulse)
//   traffic     road lamp      (2=green, 1=yellow, 0=red)
//   crossing    pedestrian lamp (same encoding)
//   req_pending latched request not yet served
//   walk_start  one-cycle pulse in the first cycle of WALK
//   phase       current state code
module traffic_light_timed #(
  parameter int CNT_W     = 8,
  parameter int MIN_GREEN = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 8,
  parameter int PEDCLR_T  = 4
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       tick,
  input  logic       waiting,
  output logic [1:0] traffic,
  output logic [1:0] crossing,
  output logic       req_pending,
  output logic       walk_start,
  output logic [2:0] phase
);

  localparam logic [2:0] S_GREEN   = 3'd0;
  localparam logic [2:0] S_YELLOW  = 3'd1;
  localparam logic [2:0] S_ALLRED1 = 3'd2;
  localparam logic [2:0] S_WALK    = 3'd3;
  localparam logic [2:0] S_PEDCLR  = 3'd4;
  localparam logic [2:0] S_ALLRED2 = 3'd5;

  localparam logic [1:0] L_RED    = 2'd0;
  localparam logic [1:0] L_YELLOW = 2'd1;
  localparam logic [1:0] L_GREEN  = 2'd2;

  // Each phase starts its timer at D-1, so a phase lasts exactly D ticks.
  function automatic logic [CNT_W-1:0] load_val(input logic [2:0] s);
    case (s)
      S_YELLOW:             load_val = CNT_W'(YELLOW_T - 1);
      S_ALLRED1, S_ALLRED2: load_val = CNT_W'(ALLRED_T - 1);
      S_WALK:               load_val = CNT_W'(WALK_T - 1);
      S_PEDCLR:             load_val = CNT_W'(PEDCLR_T - 1);
      default:              load_val = CNT_W'(MIN_GREEN - 1);
    endcase
  endfunction

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             req_q, req_d;
  logic             ws_q, ws_d;
  logic             enter_walk;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (state_q > S_ALLRED2) begin
      // Unreachable codes recover straight into a fresh GREEN.
      state_d = S_GREEN;
      timer_d = load_val(S_GREEN);
    end else if (tick) begin
      if (timer_q != '0) begin
        timer_d = timer_q - CNT_W'(1);
      end else begin
        case (state_q)
          S_GREEN:   if (req_q) state_d = S_YELLOW;
          S_YELLOW:  state_d = S_ALLRED1;
          S_ALLRED1: state_d = S_WALK;
          S_WALK:    state_d = S_PEDCLR;
          S_PEDCLR:  state_d = S_ALLRED2;
          S_ALLRED2: state_d = S_GREEN;
          default:   state_d = S_GREEN;
        endcase
        // A GREEN with no request keeps its expired timer at 0.
        if (state_d != state_q) timer_d = load_val(state_d);
      end
    end
  end

  assign enter_walk = (state_d == S_WALK) && (state_q != S_WALK);

  // Requests during WALK are ignored. Entering WALK consumes the request,
  // and that clear wins over a press on the same edge.
  always_comb begin
    req_d = req_q;
    if (waiting && (state_q != S_WALK)) req_d = 1'b1;
    if (enter_walk)                     req_d = 1'b0;
    ws_d = enter_walk;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_GREEN;
      timer_q <= CNT_W'(MIN_GREEN - 1);
      req_q   <= 1'b0;
      ws_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      req_q   <= req_d;
      ws_q    <= ws_d;
    end
  end

  // Lamps decode from registered state only.
  always_comb begin
    traffic  = L_RED;
    crossing = L_RED;
    case (state_q)
      S_GREEN:  traffic  = L_GREEN;
      S_YELLOW: traffic  = L_YELLOW;
      S_WALK:   crossing = L_GREEN;
      S_PEDCLR: crossing = L_YELLOW;
      default:  ;
    endcase
  end

  assign req_pending = req_q;
  assign walk_start  = ws_q;
  assign phase       = state_q;

endmodule
